// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch front end
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_e;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;
  localparam int ENTRY_W = 64;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular prefetch buffer; the extra pointer bit separates full from empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               clr,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clr) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop) rd_q <= rd_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC, prefetch queue and branch redirect; FETCH_HALT_DETECT_EN stops fetch on branch-to-self
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic [31:0] branch_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        halted
);
  state_e state_q;
  logic [31:0] pc_q, pc_d, pc_inc, tgt;
  logic [ENTRY_W-1:0] head;
  logic full, empty, push, pop, flush, self_br, unused_bits;
  assign tgt = {branch_addr[31:2], 2'b00};
  assign pc_inc = pc_q + PC_STEP;
  // a redirect wins over everything: the head is dropped even if decode takes it
  assign flush = branch_taken && state_q != HALT;
  assign pop = !empty && id_ready && !flush;
  assign push = state_q == FETCH && !flush && (!full || pop);
  assign pc_d = flush ? tgt : push ? pc_inc : pc_q;
`ifdef FETCH_HALT_DETECT_EN
  assign self_br = tgt == branch_pc;
  assign halted = state_q == HALT;
  assign unused_bits = ^branch_addr[1:0];
`else
  assign self_br = 1'b0;
  assign halted = 1'b0;
  assign unused_bits = ^{branch_pc, branch_addr[1:0]};
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      if (state_q != HALT) state_q <= (flush && self_br) ? HALT : FETCH;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .clr  (flush),
    .wdata({pc_inc, imem_rdata}),
    .head (head),
    .full (full),
    .empty(empty)
  );
  assign imem_addr = pc_q;
  assign if_valid = !empty;
  assign if_pc = head[63:32];
  assign if_instr = head[31:0];
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector bench for fetch_ctrl
module tb_fetch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata, branch_addr, branch_pc, if_instr, if_pc;
  logic id_ready, branch_taken, if_valid, halted;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] ba;
    logic [31:0] bp;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
  } vec_t;
  vec_t v[16];

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h0) ? 32'hE3A00014 : (32'hE1A00000 ^ a);
  endfunction

  assign imem_rdata = rom(imem_addr);
  always #5 clk = ~clk;

  fetch_ctrl #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_ready    (id_ready),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .branch_pc   (branch_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .halted      (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    chk({name, ".valid"}, {31'd0, if_valid}, 32'd1);
    chk({name, ".pc"}, if_pc, pc);
    chk({name, ".instr"}, if_instr, rom(pc - 32'd4));
  endtask

  initial begin
    id_ready = 1'b1;
    branch_taken = 1'b0;
    branch_addr = '0;
    branch_pc = '0;
    v[0]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0};
    v[1]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h4, 32'h4};
    v[2]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8, 32'h8};
    v[3]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC, 32'hC};
    v[4]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC, 32'h10};
    v[5]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC, 32'h10};
    v[6]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC, 32'h10};
    v[7]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 32'h14};
    v[8]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h14, 32'h18};
    v[9]  = '{1'b1, 1'b1, 32'h90, 32'h40, 1'b0, 32'h0, 32'h90};
    v[10] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h94, 32'h94};
    v[11] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h98, 32'h98};
    v[12] = '{1'b1, 1'b1, 32'h103, 32'h0, 1'b0, 32'h0, 32'h100};
    v[13] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 32'h104};
    v[14] = '{1'b1, 1'b1, 32'hFFFFFFFC, 32'h0, 1'b0, 32'h0, 32'hFFFFFFFC};
    v[15] = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0};
    #12;
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      id_ready = v[i].rdy;
      branch_taken = v[i].br;
      branch_addr = v[i].ba;
      branch_pc = v[i].bp;
      step();
      chk($sformatf("v%0d.valid", i), {31'd0, if_valid}, {31'd0, v[i].ev});
      chk($sformatf("v%0d.addr", i), imem_addr, v[i].eaddr);
      chk($sformatf("v%0d.halted", i), {31'd0, halted}, 32'd0);
      if (v[i].ev) begin
        chk($sformatf("v%0d.pc", i), if_pc, v[i].epc);
        chk($sformatf("v%0d.instr", i), if_instr, rom(v[i].epc - 32'd4));
      end
    end
    branch_taken = 1'b1;
    branch_addr = 32'h200;
    branch_pc = 32'h10;
    step();
    branch_taken = 1'b0;
    id_ready = 1'b0;
    repeat (3) step();
    chk("pre_rst.addr", imem_addr, 32'h208);
    chk_head("pre_rst", 32'h204);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.addr", imem_addr, 32'h0);
    chk("async_rst.valid", {31'd0, if_valid}, 32'd0);
    chk("async_rst.halted", {31'd0, halted}, 32'd0);
    step();
    chk("hold_rst.addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    id_ready = 1'b1;
    step();
    chk("rel1.valid", {31'd0, if_valid}, 32'd0);
    chk("rel1.addr", imem_addr, 32'h0);
    step();
    chk_head("rel2", 32'h4);
    chk("rel2.addr", imem_addr, 32'h4);
    id_ready = 1'b0;
    repeat (5) step();
    chk("stall.addr", imem_addr, 32'h8);
    chk_head("stall.h0", 32'h4);
    id_ready = 1'b1;
    step();
    chk_head("stall.h1", 32'h8);
    step();
    chk_head("stall.h2", 32'hC);
    branch_taken = 1'b1;
    branch_addr = 32'hB8;
    branch_pc = 32'hB8;
    step();
    branch_taken = 1'b0;
    chk("self.valid", {31'd0, if_valid}, 32'd0);
    chk("self.addr", imem_addr, 32'hB8);
`ifdef FETCH_HALT_DETECT_EN
    chk("self.halted", {31'd0, halted}, 32'd1);
    branch_taken = 1'b1;
    branch_addr = 32'h300;
    branch_pc = 32'h0;
    step();
    branch_taken = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("halt%0d.addr", k), imem_addr, 32'hB8);
      chk($sformatf("halt%0d.valid", k), {31'd0, if_valid}, 32'd0);
      chk($sformatf("halt%0d.halted", k), {31'd0, halted}, 32'd1);
      step();
    end
`else
    chk("self.halted", {31'd0, halted}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_head($sformatf("loop%0d", k), 32'hBC);
      chk($sformatf("loop%0d.halted", k), {31'd0, halted}, 32'd0);
      branch_taken = 1'b1;
      step();
      branch_taken = 1'b0;
      chk($sformatf("loop%0d.addr", k), imem_addr, 32'hB8);
      chk($sformatf("loop%0d.flush", k), {31'd0, if_valid}, 32'd0);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
